// File: rtl/karatsuba_issue_seq.sv
// karatsuba_issue_seq
//   Operand-issue and result-capture stage for the 32-bit iterative Karatsuba
//   multiplier. Operand pairs are buffered in a small FIFO and issued one at a
//   time. Each operation restarts the multiplier through its reset and then
//   enables it for MUL_LAT cycles. The 64-bit product is then captured into a
//   valid/ready output register.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a / in_b operands
//   mul_rst, mul_enable   control of the downstream multiplier
//   mul_a, mul_b, mul_c   multiplier operands and product
//   out_valid/out_ready   result handshake, out_c registered product
//   busy                  operation in flight or operands queued
//   ops_done              count of captured products (wraps)
module karatsuba_issue_seq #(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic              mul_rst,
    output logic              mul_enable,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [63:0]       mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_c,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       fifo_a [DEPTH];
    logic [31:0]       fifo_b [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [IT_W-1:0]   it_cnt;
    logic [31:0]       op_a, op_b;
    logic              full, empty, push, pop;
    logic              load_rst, run_en, capture;

    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);
    // Readiness depends only on occupancy, so a full FIFO never accepts even
    // if the FSM pops in the same cycle.
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty;

    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign mul_rst    = rst || load_rst;
    assign mul_enable = run_en && !rst;
    assign busy       = (state != IDLE) || !empty;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load_rst  = 1'b0;
        run_en    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (!empty) state_nxt = LOAD;
            LOAD: begin
                load_rst  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                run_en = 1'b1;
                if (it_cnt == IT_W'(MUL_LAT - 1)) state_nxt = DONE;
            end
            DONE: begin
                // Multiplier is frozen here (no enable, no restart), so
                // mul_c stays valid for as long as backpressure lasts.
                if (!out_valid || out_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the FIFO storage has no reset; the occupancy count and pointers
    // alone decide which entries are meaningful, and leaving the array
    // unreset lets it map onto plain RAM/registers without reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            it_cnt    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            ops_done  <= '0;
        end else begin
            state <= state_nxt;

            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                op_a   <= fifo_a[rd_ptr];
                op_b   <= fifo_b[rd_ptr];
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (state == LOAD)     it_cnt <= '0;
            else if (state == RUN) it_cnt <= it_cnt + IT_W'(1);

            // A capture in the same cycle as a transfer keeps out_valid high
            // with the new product.
            if (capture) begin
                out_c     <= mul_c;
                out_valid <= 1'b1;
                ops_done  <= ops_done + CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/karatsuba_issue_seq.md
Name: karatsuba_issue_seq

Overview:
- Operand-issue and result-capture stage placed directly upstream of the 32-bit iterative Karatsuba multiplier (single 16-bit core).
- Buffers incoming operand pairs in a small FIFO and issues one pair at a time to the multiplier.
- Restarts the multiplier's control FSM through its reset, clocks it with enable for a fixed iteration count, then captures the 64-bit product into a valid/ready output register.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, ≥2).
- MUL_LAT, 4, multiplier enable cycles from restart to stable product (≥1).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept.
- in_a  in  32  multiplicand.
- in_b  in  32  multiplier.
- mul_rst  out  1  restart to multiplier rst.
- mul_enable  out  1  to multiplier enable.
- mul_a  out  32  to multiplier A.
- mul_b  out  32  to multiplier B.
- mul_c  in  64  multiplier product C.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts.
- out_c  out  64  registered product.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- ops_done  out  CNT_W  count of captured products.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO empty; FSM IDLE; op_a/op_b = 0; out_valid = 0; out_c = 0; ops_done = 0.
  - mul_rst = 1 combinationally while rst is high; mul_enable = 0; in_ready = 0 while rst is high.
  - Reset mid-operation aborts the operation and discards FIFO contents and any held result.
- FIFO:
  - Push on in_valid & in_ready. in_ready = !full, independent of same-cycle pop; a full FIFO never accepts.
  - Pop only in IDLE when non-empty. Push and pop in the same cycle are both legal when not full.
  - Pointers wrap modulo DEPTH; occupancy count is DEPTH+1 states.
  - Order is strictly preserved.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: if FIFO non-empty, latch head into op_a/op_b, pop, go to LOAD. Else stay.
  - LOAD (1 cycle): mul_rst = 1, mul_enable = 0. Clear iteration counter. Go to RUN.
  - RUN: mul_enable = 1, counter increments each cycle. At count == MUL_LAT-1, go to DONE.
  - DONE: mul_enable = 0 and mul_rst = 0, so the multiplier holds its state.
    - If !out_valid or out_ready: out_c <= mul_c, out_valid <= 1, ops_done += 1 (wraps at 2^CNT_W), go to IDLE.
    - Else stay in DONE (backpressure).
- mul_a/mul_b = op_a/op_b at all times. They are stable from LOAD through DONE.
- Output handshake:
  - Transfer on out_valid & out_ready.
  - out_valid clears on transfer unless a DONE capture occurs in the same cycle; then out_valid stays 1 with the new out_c.
  - out_c is stable while out_valid & !out_ready.
- Latency and throughput:
  - Pair accepted into an empty FIFO with the FSM in IDLE at edge E0 gives out_valid high after edge E0+MUL_LAT+3 (7 cycles at default).
  - Sustained throughput is one product per MUL_LAT+3 cycles.
- Arithmetic: pass-through only. out_c is the 64-bit unsigned product as presented on mul_c; no truncation.
- busy = (state != IDLE) | !empty.

Test Plan:
- Single op: push a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 → out_c=0xFFFFFFFE00000001, out_valid exactly 7 cycles after accept edge, ops_done=1.
- Zero/shift operands: push (0x12345678, 0x00000000) then (0x00010000, 0x00010000) → out_c=0x0, then 0x0000000100000000, in order, 7 cycles apart.
- Fill: in_valid held high, out_ready=1, 8 pairs offered → 5 accepted before in_ready first drops (one popped immediately, DEPTH=4 buffered); all 8 eventually produced in order, ops_done=8.
- Backpressure: out_ready=0 across two ops (3×5, 7×9) → out_c holds 15; FSM waits in DONE with mul_enable=0; on out_ready=1, 15 transfers and 63 is captured in the same cycle with out_valid staying 1.
- Reset mid-RUN with 2 entries queued → next cycle: out_valid=0, busy=0, ops_done=0, in_ready=1 after rst falls; a new push of (2,3) yields out_c=6.
- Wrap: CNT_W=2, run 5 ops → ops_done sequence 1,2,3,0,1.
